// File: rtl/addsub_sequencer_pkg.sv
// Shared state encodings, opcodes and iteration count for the add/sub sequencer.
package addsub_sequencer_pkg;

  localparam int WIDTH = 4;
  localparam int ITER  = 4;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_subtractor.sv
// 4-bit adder/subtractor: r = a + b, or r = a - b as a + ~b + 1.
// On subtract, cout high means no borrow (a >= b unsigned).
module adder_subtractor (
  input  logic       select,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] r,
  output logic       cout,
  output logic       ovf
);

  logic [3:0] b_eff;
  logic [4:0] sum;

  always_comb begin
    b_eff = select ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, select};
    r     = sum[3:0];
    cout  = sum[4];
    // Signed overflow: operands of equal sign giving a result of the other sign.
    ovf   = (a[3] == b_eff[3]) && (r[3] != a[3]);
  end

endmodule

// File: rtl/addsub_sequencer.sv
// Time-shares one external adder_subtractor to run unsigned 4x4 shift-add
// multiply and 4/4 restoring divide, one iteration per clock.
module addsub_sequencer
  import addsub_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       div_by_zero,
  output logic       as_select,
  output logic [3:0] as_a,
  output logic [3:0] as_b,
  input  logic [3:0] as_r,
  input  logic       as_cout,
  input  logic       as_ovf
);

  localparam logic [1:0] LAST_COUNT = 2'(ITER - 1);

  state_t     state;
  logic [1:0] count;
  logic       op_reg;
  // hi is the accumulator (mul) or partial remainder (div); opnd is m or d.
  logic [3:0] hi;
  logic [3:0] q;
  logic [3:0] opnd;

  logic [4:0] shifted;
  logic       success;
  logic [4:0] mul_sum;
  logic [3:0] hi_next;
  logic [3:0] q_next;
  logic       unused_ovf;

  assign unused_ovf = as_ovf;

  always_comb begin
    shifted   = {hi, q[3]};
    success   = shifted[4] | as_cout;
    mul_sum   = q[0] ? {as_cout, as_r} : {1'b0, hi};
    as_select = 1'b0;
    as_a      = 4'h0;
    as_b      = 4'h0;
    if (state == ST_RUN) begin
      as_b = opnd;
      if (op_reg == OP_DIV) begin
        as_select = 1'b1;
        as_a      = shifted[3:0];
      end else begin
        as_a = hi;
      end
    end
    if (op_reg == OP_DIV) begin
      hi_next = success ? as_r : shifted[3:0];
      q_next  = {q[2:0], success};
    end else begin
      hi_next = mul_sum[4:1];
      q_next  = {mul_sum[0], q[3:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 8'h00;
      div_by_zero <= 1'b0;
      count       <= 2'd0;
      op_reg      <= 1'b0;
      hi          <= 4'h0;
      q           <= 4'h0;
      opnd        <= 4'h0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_reg      <= op;
            count       <= 2'd0;
            hi          <= 4'h0;
            div_by_zero <= 1'b0;
            q           <= (op == OP_DIV) ? x : y;
            opnd        <= (op == OP_DIV) ? y : x;
            // Divide by zero skips the iterations and reports straight away.
            if (op == OP_DIV && y == 4'h0) begin
              state       <= ST_DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              result      <= {x, 4'hF};
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          hi    <= hi_next;
          q     <= q_next;
          count <= count + 2'd1;
          if (count == LAST_COUNT) begin
            state  <= ST_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= {hi_next, q_next};
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed bench: sequencer wired to a real adder_subtractor, hand-computed results.
module tb_addsub_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       op;
  logic [3:0] x;
  logic [3:0] y;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       div_by_zero;
  logic       as_select;
  logic [3:0] as_a;
  logic [3:0] as_b;
  logic [3:0] as_r;
  logic       as_cout;
  logic       as_ovf;

  int tests_run;
  int tests_failed;

  addsub_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .x(x), .y(y),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero),
    .as_select(as_select), .as_a(as_a), .as_b(as_b),
    .as_r(as_r), .as_cout(as_cout), .as_ovf(as_ovf)
  );

  adder_subtractor alu (
    .select(as_select), .a(as_a), .b(as_b),
    .r(as_r), .cout(as_cout), .ovf(as_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issues one request, scrambles x/y after acceptance, and waits (bounded) for done.
  task automatic apply_stimulus(input string tag, input logic o, input logic [3:0] xi, input logic [3:0] yi,
                                input int exp_latency, input logic [7:0] exp_result, input logic exp_dbz);
    int cycles;
    int busy_cycles;
    @(negedge clk);
    start = 1'b1; op = o; x = xi; y = yi;
    @(posedge clk); #1;
    start = 1'b0; x = ~xi; y = ~yi;
    cycles = 0;
    busy_cycles = 0;
    if (busy) check_output({tag, "_select"}, {7'b0, as_select}, {7'b0, o});
    while (done !== 1'b1 && cycles < 20) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      cycles++;
    end
    check_output({tag, "_done"}, {7'b0, done}, 8'h01);
    check_output({tag, "_latency"}, 8'(cycles), 8'(exp_latency));
    check_output({tag, "_busy_cycles"}, 8'(busy_cycles), 8'(exp_latency));
    check_output({tag, "_result"}, result, exp_result);
    check_output({tag, "_dbz"}, {7'b0, div_by_zero}, {7'b0, exp_dbz});
    @(posedge clk); #1;
    check_output({tag, "_done_pulse"}, {7'b0, done}, 8'h00);
    check_output({tag, "_result_hold"}, result, exp_result);
  endtask

  initial begin
    int done_pulses;
    int cycles;
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1; start = 1'b0; op = 1'b0; x = 4'h0; y = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("reset_busy", {7'b0, busy}, 8'h00);
    check_output("reset_done", {7'b0, done}, 8'h00);
    check_output("reset_result", result, 8'h00);
    check_output("reset_dbz", {7'b0, div_by_zero}, 8'h00);
    check_output("idle_as", {as_select, as_a, 3'b0}, 8'h00);
    check_output("idle_as_b", {4'h0, as_b}, 8'h00);

    apply_stimulus("mul_7x1", 1'b0, 4'd7, 4'd1, 4, 8'h07, 1'b0);
    apply_stimulus("mul_15x15", 1'b0, 4'd15, 4'd15, 4, 8'hE1, 1'b0);
    apply_stimulus("mul_0x9", 1'b0, 4'd0, 4'd9, 4, 8'h00, 1'b0);
    apply_stimulus("div_13_4", 1'b1, 4'd13, 4'd4, 4, 8'h13, 1'b0);
    apply_stimulus("div_15_1", 1'b1, 4'd15, 4'd1, 4, 8'h0F, 1'b0);
    apply_stimulus("div_3_7", 1'b1, 4'd3, 4'd7, 4, 8'h30, 1'b0);
    apply_stimulus("div_9_0", 1'b1, 4'd9, 4'd0, 0, 8'h9F, 1'b1);
    apply_stimulus("mul_after_dbz", 1'b0, 4'd3, 4'd5, 4, 8'h0F, 1'b0);

    // Requests while running and in DONE must be ignored.
    @(negedge clk);
    start = 1'b1; op = 1'b0; x = 4'd15; y = 4'd15;
    @(posedge clk); #1;
    op = 1'b1; x = 4'd1; y = 4'd1;
    done_pulses = 0;
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (done === 1'b1) done_pulses++;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_pulses++;
    end
    check_output("ignore_latency", 8'(cycles), 8'd4);
    check_output("ignore_result", result, 8'hE1);
    check_output("ignore_pulses", 8'(done_pulses), 8'd1);
    check_output("ignore_busy", {7'b0, busy}, 8'h00);

    // Reset in the second RUN cycle aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; op = 1'b0; x = 4'd15; y = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_output("abort_busy", {7'b0, busy}, 8'h00);
    check_output("abort_done", {7'b0, done}, 8'h00);
    check_output("abort_result", result, 8'h00);
    done_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_pulses++;
    end
    check_output("abort_quiet", 8'(done_pulses), 8'd0);
    apply_stimulus("mul_6x5", 1'b0, 4'd6, 4'd5, 4, 8'h1E, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
